trigger_pattern_gen: RTL

- Stimulus source for the trigger matcher: drives the matcher's start level and 33-bit data bus.
- The programmed pattern appears exactly OFFSET cycles after start rises, so the matcher's out pulses on that cycle.
- Used for on-board self-test of the analyzer trigger path and as the bench driver for the matcher.
- Sits between the control/host logic, which issues go and abort, and the matcher's start and data inputs.

---
 rtl/patgen_pkg.sv | 17 +
 rtl/patgen_lfsr16.sv | 28 ++
 rtl/trigger_pattern_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/patgen_pkg.sv
// Shared types and constants for the trigger pattern generator and its LFSR filler.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 33;
  localparam int CNT_W_DEF  = 17;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/patgen_lfsr16.sv
// 16-bit Fibonacci LFSR for pseudo-random filler words; only built when
// PATGEN_LFSR_FILL_EN is defined.
`ifdef PATGEN_LFSR_FILL_EN
module patgen_lfsr16
  import patgen_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule
`endif

// File: rtl/trigger_pattern_gen.sv
// Drives the trigger matcher's start level and data bus so the programmed burst lands
// OFFSET cycles after start rises. Optional LFSR filler: PATGEN_LFSR_FILL_EN.
module trigger_pattern_gen
  import patgen_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                CNT_W     = CNT_W_DEF,
  parameter int                OFFSET    = 1,
  parameter logic [DATA_W-1:0] PATTERN   = 4,
  parameter int                LENGTH    = 1,
  parameter logic [DATA_W-1:0] STEP      = 0,
  parameter int                RUN_LEN   = 16,
  parameter logic [DATA_W-1:0] IDLE_WORD = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go,
  input  logic              abort,
  output logic              start_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  // Word index is one bit wider than cnt so cnt+1 at the last run cycle cannot wrap.
  localparam int               KW     = CNT_W + 1;
  localparam logic [KW-1:0]    OFF_K  = KW'(OFFSET);
  localparam logic [KW-1:0]    END_K  = KW'(OFFSET + LENGTH);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(RUN_LEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [KW-1:0]       k_nxt;
  logic                in_burst;
  logic [DATA_W-1:0]   burst_w;
  logic [DATA_W-1:0]   filler;
  logic [DATA_W-1:0]   word_nxt;

  function automatic logic [DATA_W-1:0] burst_val(input logic [KW-1:0] k);
    logic [DATA_W-1:0] idx;
    idx = DATA_W'(k - OFF_K);
    return PATTERN + idx * STEP;
  endfunction

  // Index of the word that will be on data_out after the coming edge.
  always_comb begin
    k_nxt    = (state_q == RUN) ? ({1'b0, cnt_q} + KW'(1)) : '0;
    in_burst = (k_nxt >= OFF_K) && (k_nxt < END_K);
    burst_w  = burst_val(k_nxt);
  end

`ifdef PATGEN_LFSR_FILL_EN
  logic [15:0]       lfsr_w;
  logic [DATA_W-1:0] fill_raw;
  logic [DATA_W-1:0] fill_cand;

  patgen_lfsr16 u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state_q == RUN),
    .q       (lfsr_w)
  );

  // Invert the filler if it would alias a burst word and cause a false match.
  always_comb begin
    fill_raw  = DATA_W'(lfsr_w);
    fill_cand = (STEP == '0) ? PATTERN : burst_w;
    filler    = (fill_raw == fill_cand) ? ~fill_raw : fill_raw;
  end
`else
  assign filler = IDLE_WORD;
`endif

  assign word_nxt = in_burst ? burst_w : filler;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        data_d  = IDLE_WORD;
        busy_d  = 1'b0;
        if (go && !abort) begin
          state_d = RUN;
          start_d = 1'b1;
          cnt_d   = '0;
          data_d  = word_nxt;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          start_d = 1'b0;
          data_d  = IDLE_WORD;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == LAST_K) begin
          state_d = DONE;
          start_d = 1'b0;
          data_d  = IDLE_WORD;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          data_d = word_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
        start_d = 1'b0;
        data_d  = IDLE_WORD;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        start_d = 1'b0;
        data_d  = IDLE_WORD;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign start_out = start_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
